// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: shared period counter, per-channel duty, run-count and end pulse.
// Optional output polarity register is enabled by defining PWM_TIMER_POLARITY_EN.

module pwm_timer_multi_ch #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             load,
    input  logic             run_n,
    input  logic [WIDTH-1:0] cnt_n,
    input  logic             pol_n,
    output logic             pwm
);
    logic [WIDTH-1:0] duty_s, duty_a, duty_n;

    // The duty used for the next cycle is the shadow whenever the actives reload on this edge.
    assign duty_n = load ? duty_s : duty_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            duty_s <= '0;
            duty_a <= '0;
            pwm    <= 1'b0;
        end else begin
            if (we) duty_s <= wdata;
            duty_a <= duty_n;
            pwm    <= (run_n && (cnt_n < duty_n)) ^ pol_n;
        end
    end
endmodule

module pwm_timer_multi #(
    parameter int WIDTH     = 16,
    parameter int NCH       = 2,
    parameter int ADDR_W    = 3,
    parameter int END_PULSE = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [NCH-1:0]    o_pwm,
    output logic              o_busy,
    output logic              o_timer_end
);
    localparam int EW = (END_PULSE > 1) ? $clog2(END_PULSE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] period_s, period_a, stop_s, stop_a;
    logic [WIDTH-1:0] cnt, cnt_n, cyc, cyc_n;
    logic [EW-1:0]    end_cnt, end_cnt_n;
    logic             load, run_n, tend_n, last;
    logic [NCH-1:0]   pol_n;

    // A zero period reloaded mid-run degenerates to one-clock periods rather than a 2**WIDTH count.
    assign last   = (period_a <= WIDTH'(1)) || (cnt == period_a - WIDTH'(1));
    assign run_n  = (state_n == S_RUN);
    assign o_busy = (state == S_RUN);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cyc_n     = cyc;
        end_cnt_n = end_cnt;
        load      = 1'b0;
        tend_n    = 1'b0;
        case (state)
            S_IDLE: begin
                // Actives track shadows while idle, so the start edge sees the pre-write values.
                load      = 1'b1;
                cnt_n     = '0;
                cyc_n     = '0;
                end_cnt_n = '0;
                if (i_start && (period_s != '0)) state_n = S_RUN;
            end
            S_RUN: begin
                if (i_abort) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    cyc_n   = '0;
                end else if (last) begin
                    cnt_n = '0;
                    if ((stop_a != '0) && (cyc + WIDTH'(1) == stop_a)) begin
                        state_n   = S_END;
                        cyc_n     = '0;
                        end_cnt_n = '0;
                        tend_n    = 1'b1;
                    end else begin
                        cyc_n = cyc + WIDTH'(1);
                        load  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
            end
            S_END: begin
                if (i_abort || (end_cnt == EW'(END_PULSE - 1))) begin
                    state_n   = S_IDLE;
                    end_cnt_n = '0;
                end else begin
                    end_cnt_n = end_cnt + EW'(1);
                    tend_n    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            period_s    <= '0;
            period_a    <= '0;
            stop_s      <= '0;
            stop_a      <= '0;
            cnt         <= '0;
            cyc         <= '0;
            end_cnt     <= '0;
            o_timer_end <= 1'b0;
        end else begin
            if (i_we && (i_addr == ADDR_W'(0))) period_s <= i_wdata;
            if (i_we && (i_addr == ADDR_W'(1))) stop_s   <= i_wdata;
            if (load) begin
                period_a <= period_s;
                stop_a   <= stop_s;
            end
            state       <= state_n;
            cnt         <= cnt_n;
            cyc         <= cyc_n;
            end_cnt     <= end_cnt_n;
            o_timer_end <= tend_n;
        end
    end

`ifdef PWM_TIMER_POLARITY_EN
    logic [NCH-1:0] pol_s, pol_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pol_s <= '0;
            pol_a <= '0;
        end else begin
            if (i_we && (i_addr == ADDR_W'(NCH + 2))) pol_s <= i_wdata[NCH-1:0];
            if (load) pol_a <= pol_s;
        end
    end

    assign pol_n = load ? pol_s : pol_a;
`else
    assign pol_n = '0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_timer_multi_ch #(.WIDTH(WIDTH)) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .we      (i_we && (i_addr == ADDR_W'(k + 2))),
            .wdata   (i_wdata),
            .load    (load),
            .run_n   (run_n),
            .cnt_n   (cnt_n),
            .pol_n   (pol_n[k]),
            .pwm     (o_pwm[k])
        );
    end
endmodule

// File: tb/tb_pwm_timer_multi.sv
// Scoreboard bench for pwm_timer_multi: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pwm_timer_multi;
    localparam int WIDTH = 16, NCH = 2, ADDR_W = 3, END_PULSE = 10;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_we = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [WIDTH-1:0]  i_wdata = '0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [NCH-1:0]    o_pwm;
    logic              o_busy;
    logic              o_timer_end;

    pwm_timer_multi #(.WIDTH(WIDTH), .NCH(NCH), .ADDR_W(ADDR_W), .END_PULSE(END_PULSE)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .o_pwm       (o_pwm),
        .o_busy      (o_busy),
        .o_timer_end (o_timer_end)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         at;
        logic [1:0] pwm;
        logic       busy;
        logic       tend;
        int         tid;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc_no = 0;
    int   tid = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge i_clk) cyc_no <= cyc_no + 1;

    task chk(input int t, input int at, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL case%0d cycle %0d: pwm/busy/end got %b required %b", t, at, act, req);
        end
    endtask

    always @(negedge i_clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc_no) begin
            e = exp_q.pop_front();
            chk(e.tid, e.at, {o_pwm, o_busy, o_timer_end}, {e.pwm, e.busy, e.tend});
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Queue the outputs expected right after the next rising edge, then take that edge.
    task automatic expect_nx(input logic [1:0] p, input logic b, input logic t);
        exp_q.push_back('{at: cyc_no + 1, pwm: p, busy: b, tend: t, tid: tid});
        tick();
    endtask

    task automatic wr(input int a, input int d);
        i_we    = 1'b1;
        i_addr  = ADDR_W'(a);
        i_wdata = WIDTH'(d);
        tick();
        i_we    = 1'b0;
    endtask

    task automatic end_seq(input logic [1:0] idl);
        for (int j = 0; j < END_PULSE; j++) begin
            i_start = (j >= 2 && j < 6);
            expect_nx(idl, 1'b0, 1'b1);
        end
        i_start = 1'b0;
        expect_nx(idl, 1'b0, 1'b0);
        expect_nx(idl, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        tid = 0;
        #3;
        chk(tid, 0, {o_pwm, o_busy, o_timer_end}, 4'b0000);
        #9;
        i_rst_n = 1'b1;
        tick();

        // Basic run: period 10, duties 3/7, two periods
        tid = 1;
        wr(0, 10); wr(1, 2); wr(2, 3); wr(3, 7);
        for (int j = 0; j < 20; j++) begin
            i_start = (j == 0);
            expect_nx({(j % 10) < 7, (j % 10) < 3}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        end_seq(2'b00);

        // Boundary duties: 0 -> always low, >= period -> always high
        tid = 2;
        wr(2, 0); wr(3, 12); wr(1, 1);
        for (int j = 0; j < 10; j++) begin
            i_start = (j == 0);
            expect_nx(2'b10, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        end_seq(2'b00);

        // Mid-run duty write lands at the next wrap
        tid = 3;
        wr(0, 8); wr(2, 2); wr(1, 3);
        for (int j = 0; j < 24; j++) begin
            i_start = (j == 0);
            i_we    = (j == 5);
            i_addr  = ADDR_W'(2);
            i_wdata = WIDTH'(6);
            expect_nx({1'b1, (j % 8) < ((j < 8) ? 2 : 6)}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        i_we    = 1'b0;
        end_seq(2'b00);

        // Write on the start edge only reaches actives at the first wrap; abort at cycle 12
        tid = 4;
        wr(0, 5); wr(1, 0);
        for (int j = 0; j < 12; j++) begin
            i_start = (j == 0);
            i_we    = (j == 0);
            i_addr  = ADDR_W'(2);
            i_wdata = WIDTH'(1);
            expect_nx({1'b1, (j < 5) ? 1'b1 : ((j % 5) < 1)}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        i_we    = 1'b0;
        i_abort = 1'b1;
        expect_nx(2'b00, 1'b0, 1'b0);
        i_abort = 1'b0;
        for (int j = 0; j < 3; j++) expect_nx(2'b00, 1'b0, 1'b0);
        tid = 5;
        for (int j = 0; j < 7; j++) begin
            i_start = (j == 0);
            expect_nx({1'b1, (j % 5) < 1}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        i_abort = 1'b1;
        expect_nx(2'b00, 1'b0, 1'b0);
        i_abort = 1'b0;
        expect_nx(2'b00, 1'b0, 1'b0);

        // Start with period 0 is ignored
        tid = 6;
        wr(0, 0);
        i_start = 1'b1;
        for (int j = 0; j < 3; j++) expect_nx(2'b00, 1'b0, 1'b0);
        i_start = 1'b0;

        // Async reset mid-run clears outputs without a clock edge
        tid = 7;
        wr(0, 5);
        for (int j = 0; j < 4; j++) begin
            i_start = (j == 0);
            expect_nx({1'b1, (j % 5) < 1}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk(tid, cyc_no, {o_pwm, o_busy, o_timer_end}, 4'b0000);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        // Shadow period was cleared by reset, so start stays idle
        i_start = 1'b1;
        for (int j = 0; j < 2; j++) expect_nx(2'b00, 1'b0, 1'b0);
        i_start = 1'b0;

        tid = 8;
`ifdef PWM_TIMER_POLARITY_EN
        wr(4, 1); wr(0, 10); wr(2, 3); wr(1, 1);
        expect_nx(2'b01, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            i_start = (j == 0);
            expect_nx({1'b0, !((j % 10) < 3)}, 1'b1, 1'b0);
        end
        i_start = 1'b0;
        end_seq(2'b01);
`else
        // Address NCH+2 is unmapped: no effect on outputs
        wr(4, 3);
        expect_nx(2'b00, 1'b0, 1'b0);
        expect_nx(2'b00, 1'b0, 1'b0);
`endif

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
